addsub_pipe: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath; generalises the 4-bit ripple add/sub to WIDTH bits.
- Carry chain is cut every SLICE bits into register stages, one slice per stage. Issue rate is one op per clock.
- Valid/ready handshake on both sides; outputs are Sum plus N/Z/V flags for the flag register.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/addsub_slice.sv | 23 ++
 rtl/addsub_pipe.sv | 157 +++++++++++++++
 tb/tb_addsub_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants and saturation helpers for addsub_pipe
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 16;
    localparam int ADDSUB_SLICE = 4;

    // Bit positions of the flags inside the registered flag vector
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    // Largest positive two's-complement value of a w-bit word (0111..1)
    function automatic logic [63:0] sat_max_pos(input int w);
        sat_max_pos = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word (1000..0)
    function automatic logic [63:0] sat_min_neg(input int w);
        sat_min_neg = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational SLICE-bit ripple adder slice
// Ports: a, b_eff (B already conditionally inverted), cin -> s, cout,
//        c_msb (carry into the top bit of the slice). SLICE must be >= 2.
module addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b_eff,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // Low bits summed together; the extra top bit is the carry into the MSB
    logic [SLICE-1:0] low;

    assign low   = {1'b0, a[SLICE-2:0]} + {1'b0, b_eff[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
    assign c_msb = low[SLICE-1];
    assign s     = {a[SLICE-1] ^ b_eff[SLICE-1] ^ c_msb, low[SLICE-2:0]};
    assign cout  = (a[SLICE-1] & b_eff[SLICE-1]) | (c_msb & (a[SLICE-1] ^ b_eff[SLICE-1]));

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined WIDTH-bit two's-complement add/sub with N/Z/V flags
// Ports: clk, rst_n (async active-low); in_valid/in_ready, A, B, sub (operand beat);
//        out_valid/out_ready, Sum, Flag_N, Flag_Z, Flag_V (result beat).
// Build macro: ADDSUB_SAT_EN clamps Sum on signed overflow (Flag_V stays raw).
// WIDTH must be a multiple of SLICE and at least 2*SLICE.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH,
    parameter int SLICE = ADDSUB_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Flag_N,
    output logic             Flag_Z,
    output logic             Flag_V
);

    localparam int NSTAGE = WIDTH / SLICE;

    // One enable for the whole pipe: everything moves unless the output is blocked
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTAGE; k++) begin : stg
        localparam int LO = k * SLICE;
        localparam int BW = WIDTH - LO;

        logic             v_q;
        logic             sub_q;
        logic             c_q;    // carry into this slice (sub itself for stage 0)
        logic [WIDTH-1:0] ar_q;   // finished result below LO, operand A from LO up
        logic [BW-1:0]    bh_q;   // operand B from LO up
        logic [SLICE-1:0] s;
        logic             cout;
        logic             cmsb;
        logic [WIDTH-1:0] ar_nx;

        addsub_slice #(.SLICE(SLICE)) u_slice (
            .a     (ar_q[LO +: SLICE]),
            .b_eff (bh_q[SLICE-1:0] ^ {SLICE{sub_q}}),
            .cin   (c_q),
            .s     (s),
            .cout  (cout),
            .c_msb (cmsb)
        );

        // Splice this slice's result over the A bits it consumed
        always_comb begin
            ar_nx            = ar_q;
            ar_nx[LO +: SLICE] = s;
        end

        if (k == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    sub_q <= 1'b0;
                    c_q   <= 1'b0;
                    ar_q  <= '0;
                    bh_q  <= '0;
                end else if (adv) begin
                    v_q <= in_valid;
                    if (in_valid) begin
                        sub_q <= sub;
                        c_q   <= sub;
                        ar_q  <= A;
                        bh_q  <= B;
                    end
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    sub_q <= 1'b0;
                    c_q   <= 1'b0;
                    ar_q  <= '0;
                    bh_q  <= '0;
                end else if (adv) begin
                    v_q   <= stg[k-1].v_q;
                    sub_q <= stg[k-1].sub_q;
                    c_q   <= stg[k-1].cout;
                    ar_q  <= stg[k-1].ar_nx;
                    bh_q  <= stg[k-1].bh_q[BW+SLICE-1:SLICE];
                end
            end
        end

        // Only the top slice's MSB carry feeds the overflow flag
        if (k < NSTAGE - 1) begin : g_mid
            logic unused_cmsb;
            assign unused_cmsb = cmsb;
        end
    end

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             ovf;

    assign raw = stg[NSTAGE-1].ar_nx;
    assign ovf = stg[NSTAGE-1].cout ^ stg[NSTAGE-1].cmsb;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min_neg(WIDTH));

    // On overflow the true result has the sign of A, so clamp toward it.
    // The last stage's ar_q MSB is still operand A's MSB.
    always_comb begin
        res = raw;
        if (ovf) begin
            res = stg[NSTAGE-1].ar_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign res = raw;
`endif

    logic [2:0] flags_d;
    logic [2:0] flags_q;

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = res[WIDTH-1];
        flags_d[FLAG_Z] = (res == '0);
        flags_d[FLAG_V] = ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Sum       <= '0;
            flags_q   <= '0;
        end else if (adv) begin
            out_valid <= stg[NSTAGE-1].v_q;
            if (stg[NSTAGE-1].v_q) begin
                Sum     <= res;
                flags_q <= flags_d;
            end
        end
    end

    assign Flag_N = flags_q[FLAG_N];
    assign Flag_Z = flags_q[FLAG_Z];
    assign Flag_V = flags_q[FLAG_V];

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - scoreboard bench for addsub_pipe (WIDTH=16, SLICE=4)
module tb_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sub = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] Sum;
    logic        Flag_N;
    logic        Flag_Z;
    logic        Flag_V;

    addsub_pipe #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Flag_N    (Flag_N),
        .Flag_Z    (Flag_Z),
        .Flag_V    (Flag_V)
    );

    always #5 clk = ~clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [18:0] exp_q[$];     // {Sum, N, Z, V}
    logic        rnd_done = 1'b0;

    // Hand-computed expectations whose value depends on the saturation build
`ifdef ADDSUB_SAT_EN
    localparam logic [18:0] E_7FFF_P1    = {16'h7FFF, 3'b001};
    localparam logic [18:0] E_8000_M1    = {16'h8000, 3'b101};
    localparam logic [18:0] E_8000_P8000 = {16'h8000, 3'b101};
    localparam logic [18:0] E_4000_P4000 = {16'h7FFF, 3'b001};
`else
    localparam logic [18:0] E_7FFF_P1    = {16'h8000, 3'b101};
    localparam logic [18:0] E_8000_M1    = {16'h7FFF, 3'b001};
    localparam logic [18:0] E_8000_P8000 = {16'h0000, 3'b011};
    localparam logic [18:0] E_4000_P4000 = {16'h8000, 3'b101};
`endif

    logic [15:0] bp_a[6] = '{16'h0001, 16'h0010, 16'h0100, 16'h0000, 16'h4000, 16'hABCD};
    logic [15:0] bp_b[6] = '{16'h0001, 16'h0020, 16'h0001, 16'h0001, 16'h4000, 16'h1111};
    logic        bp_s[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [18:0] bp_e[6] = '{{16'h0002, 3'b000}, {16'h0030, 3'b000}, {16'h00FF, 3'b000},
                             {16'hFFFF, 3'b100}, E_4000_P4000,       {16'hBCDE, 3'b100}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent golden model: overflow from operand/result signs
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] bb;
        logic [15:0] r;
        logic [16:0] full;
        logic        v;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, s};
        r    = full[15:0];
        v    = (a[15] == bb[15]) && (r[15] != a[15]);
`ifdef ADDSUB_SAT_EN
        if (v) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {r, r[15], (r == 16'h0000), v};
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [18:0] e);
        int n = 0;
        @(negedge clk);
        A = a; B = b; sub = s; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 after %0d cycles", n);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; first out_valid must follow 4 edges later
    task automatic measure_latency(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
        chk(name, n, 4);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: pops on every taken result, checks hold value while stalled
    always @(negedge clk) begin
        logic [18:0] e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_result: got %h expected none at %0t", {Sum, Flag_N, Flag_Z, Flag_V}, $time);
            end else if (out_ready) begin
                e = exp_q.pop_front();
                chk("result", {Sum, Flag_N, Flag_Z, Flag_V}, e);
            end else begin
                chk("stall_hold", {Sum, Flag_N, Flag_Z, Flag_V}, exp_q[0]);
                chk("stall_in_ready", in_ready, 0);
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", Sum, 0);
        chk("reset_flags", {Flag_N, Flag_Z, Flag_V}, 0);
        chk("reset_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        issue(16'h1234, 16'h0FFF, 1'b0, {16'h2233, 3'b000});
        measure_latency("latency_first");
        issue(16'h5555, 16'h5555, 1'b1, {16'h0000, 3'b010});
        issue(16'h0001, 16'h0002, 1'b1, {16'hFFFF, 3'b100});
        issue(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 3'b010});
        issue(16'h7FFF, 16'h0001, 1'b0, E_7FFF_P1);
        issue(16'h8000, 16'h0001, 1'b1, E_8000_M1);
        issue(16'h8000, 16'h8000, 1'b0, E_8000_P8000);
        drain("drain_directed");

        // Backpressure: consumer stalls for 5 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 6; i++) issue(bp_a[i], bp_b[i], bp_s[i], bp_e[i]);
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset with ops in flight
        for (int i = 0; i < 5; i++) issue(16'h0100 + 16'(i), 16'h0011, 1'b0, {16'h0111 + 16'(i), 3'b000});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_sum", Sum, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (8) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("no_stale_after_reset", seen, 0);
        end
        issue(16'h0003, 16'h0004, 1'b0, {16'h0007, 3'b000});
        measure_latency("latency_after_reset");
        drain("drain_reset");

        // Random regression with random consumer backpressure
        fork
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [15:0] ra;
                    logic [15:0] rb;
                    logic        rs;
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rs = 1'($urandom_range(0, 1));
                    issue(ra, rb, rs, model(ra, rb, rs));
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        drain("drain_random");

        // Throughput: 8 back-to-back ops must emerge on 8 consecutive cycles
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] ta;
                    ta = 16'h1000 * 16'(i) + 16'h0123;
                    issue(ta, 16'h0101, 1'(i % 2), model(ta, 16'h0101, 1'(i % 2)));
                end
            end
            begin
                int n = 0;
                int run = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 30);
                while (out_valid && run < 20) begin
                    run++;
                    @(posedge clk);
                    #1;
                end
                chk("throughput_run", run, 8);
            end
        join
        drain("drain_throughput");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
